flp_mul_issue: RTL and testbench
================================

FLP_MUL_ISSUE -- requirements
Module: flp_mul_issue

Interface
REQ-001 SHALL have parameter EWIDTH, default 8, exponent width.
REQ-002 SHALL have parameter SWIDTH, default 23, significand width; FWIDTH = 1+EWIDTH+SWIDTH.
REQ-003 SHALL have parameter DEPTH, default 4, total operand-pair capacity; power of two, >= 2.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port nrst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_flush  input  1  discard all held operand pairs.
REQ-007 SHALL have port i_a  input  FWIDTH  operand A, IEEE-style packed float.
REQ-008 SHALL have port i_b  input  FWIDTH  operand B, IEEE-style packed float.
REQ-009 SHALL have port i_valid  input  1  i_a/i_b valid.
REQ-010 SHALL have port o_ready  output  1  block accepts a pair this cycle.
REQ-011 SHALL have port o_a  output  FWIDTH  operand A to multiplier stage.
REQ-012 SHALL have port o_b  output  FWIDTH  operand B to multiplier stage.
REQ-013 SHALL have port o_spec  output  1  pair needs no significand multiply (zero/inf/NaN operand).
REQ-014 SHALL have port o_valid  output  1  o_a/o_b/o_spec valid.
REQ-015 SHALL have port i_ready  input  1  multiplier stage accepts pair.
REQ-016 SHALL have port o_count  output  $clog2(DEPTH)+1  pairs currently held, output register included.

Function
REQ-017 Push SHALL occur when i_valid & o_ready; pop SHALL occur when o_valid & i_ready.
REQ-018 o_ready SHALL be registered and equal (count < DEPTH); no combinational path from i_ready to o_ready.
REQ-019 Storage SHALL be DEPTH-1 FIFO slots plus one output register holding the head pair.
REQ-020 Empty block, push at cycle N -> pair SHALL appear on o_a/o_b with o_valid=1 at cycle N+1 (latency 1).
REQ-021 On pop with FIFO non-empty, next FIFO entry SHALL load output register same edge; o_valid stays 1.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; order strictly FIFO.
REQ-023 Push to output register directly SHALL occur only when FIFO slots empty and (output register empty or popping).
REQ-024 o_a/o_b/o_valid/o_spec SHALL hold stable while o_valid=1 and i_ready=0.
REQ-025 Read/write pointers SHALL be log2(DEPTH-1 rounded up) bits, wrap modulo slot count without gap.
REQ-026 o_spec SHALL be computed at push: exponent of A or B all-zeros with zero significand, or all-ones exponent; stored with pair.
REQ-027 Subnormal operand (exp 0, significand nonzero) SHALL NOT set o_spec.
REQ-028 Push when count = DEPTH SHALL not occur (o_ready=0); i_valid then ignored, data not stored.
REQ-029 i_flush=1 SHALL next edge set count=0, pointers=0, o_valid=0, o_ready=1; push and pop that cycle ignored.
REQ-030 o_count SHALL update every edge as count + push - pop, range 0..DEPTH.
REQ-031 o_a/o_b contents when o_valid=0 SHALL be don't-care for checking.

Reset
REQ-032 nrst=0 at edge SHALL force o_valid=0, o_spec=0, o_count=0, o_ready=1, pointers=0; o_a/o_b=0.
REQ-033 Reset SHALL take priority over i_flush, push and pop; mid-operation reset discards all held pairs.
REQ-034 First push SHALL be accepted on first edge with nrst=1.

Verification
REQ-035 Reset, push A=0x3F800000 B=0x40000000 at cycle 1, i_ready=1 -> cycle 2 o_valid=1, o_a=0x3F800000, o_b=0x40000000, o_spec=0, cycle 3 o_valid=0.
REQ-036 i_ready=0, push 5 pairs back-to-back (DEPTH=4) -> 4 accepted, o_ready=0 after 4th, o_count=4; release i_ready -> pairs 1..4 in order, o_count 3,2,1,0.
REQ-037 Full block, i_valid=1 and i_ready=1 same cycle -> pop only, o_count 4->3, o_ready=1 next cycle.
REQ-038 Push B=0x00000000, B=0x7F800000, B=0x7FC00000, B=0x00000001 (A=1.0) -> o_spec 1,1,1,0.
REQ-039 Count=3, i_flush=1 with i_valid=1 -> next cycle o_valid=0, o_count=0, o_ready=1; flushed pair never emitted.
REQ-040 Continuous push/pop at i_ready toggling 1010 for 64 pairs -> output sequence equals input sequence, pointers wrap, no loss/duplication.

Source files
------------

// File: rtl/flp_mul_issue.sv
`timescale 1ns/1ps
// flp_mul_issue: operand-pair issue buffer in front of a floating-point
// multiplier. Pairs are queued in a small circular FIFO that feeds one output
// register. The output register always holds the oldest pair. Each pair
// carries a flag marking it as special (zero, infinity or NaN operand), so the
// multiplier can skip the significand product for it.
module flp_mul_issue #(
  parameter int EWIDTH = 8,
  parameter int SWIDTH = 23,
  parameter int DEPTH  = 4,
  localparam int FWIDTH = 1 + EWIDTH + SWIDTH
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     i_flush,
  input  logic [FWIDTH-1:0]        i_a,
  input  logic [FWIDTH-1:0]        i_b,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [FWIDTH-1:0]        o_a,
  output logic [FWIDTH-1:0]        o_b,
  output logic                     o_spec,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count
);

  // The output register counts toward capacity, so the FIFO needs one slot fewer.
  localparam int SLOTS = DEPTH - 1;
  localparam int PW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_SLOT  = PW'(SLOTS - 1);

  logic [FWIDTH-1:0] slot_a    [SLOTS];
  logic [FWIDTH-1:0] slot_b    [SLOTS];
  logic              slot_spec [SLOTS];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [CW-1:0] fifo_count;

  logic push;
  logic pop;
  logic fifo_empty;
  logic load_direct;
  logic load_fifo;
  logic in_spec;

  // An operand is special when it is zero (not subnormal), infinity or NaN.
  function automatic logic is_special(input logic [EWIDTH-1:0] exp_f,
                                      input logic [SWIDTH-1:0] sig_f);
    return (exp_f == '1) || ((exp_f == '0) && (sig_f == '0));
  endfunction

  // The slot count is not always a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] ptr);
    return (ptr == LAST_SLOT) ? '0 : ptr + PW'(1);
  endfunction

  // Handshakes, routing decisions and the next occupancy value.
  always_comb begin
    push        = i_valid & o_ready;
    pop         = o_valid & i_ready;
    fifo_count  = count - CW'(o_valid);
    fifo_empty  = (fifo_count == '0);
    load_direct = push & fifo_empty & (~o_valid | pop);
    load_fifo   = pop & ~fifo_empty;
    count_next  = count + CW'(push) - CW'(pop);
    in_spec     = is_special(i_a[FWIDTH-2:SWIDTH], i_a[SWIDTH-1:0]) |
                  is_special(i_b[FWIDTH-2:SWIDTH], i_b[SWIDTH-1:0]);
  end

  // FIFO slot storage. It has no reset because the pointers define what is live.
  always_ff @(posedge clk) begin
    if (push && !load_direct) begin
      slot_a[wr_ptr]    <= i_a;
      slot_b[wr_ptr]    <= i_b;
      slot_spec[wr_ptr] <= in_spec;
    end
  end

  // Occupancy, pointers and the output register. Reset wins over flush, and flush wins over traffic.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_spec  <= 1'b0;
      o_a     <= '0;
      o_b     <= '0;
    end else if (i_flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_spec  <= 1'b0;
    end else begin
      count   <= count_next;
      o_ready <= (count_next < FULL_COUNT);
      if (push && !load_direct) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (load_fifo) begin
        o_a     <= slot_a[rd_ptr];
        o_b     <= slot_b[rd_ptr];
        o_spec  <= slot_spec[rd_ptr];
        o_valid <= 1'b1;
        rd_ptr  <= bump(rd_ptr);
      end else if (load_direct) begin
        o_a     <= i_a;
        o_b     <= i_b;
        o_spec  <= in_spec;
        o_valid <= 1'b1;
      end else if (pop) begin
        o_valid <= 1'b0;
        o_spec  <= 1'b0;
      end
    end
  end

  assign o_count = count;

endmodule

// File: tb/tb_flp_mul_issue.sv
`timescale 1ns/1ps
// Testbench for flp_mul_issue: a queue-based reference model plus directed vectors.
module tb_flp_mul_issue;

  localparam int EWIDTH = 8;
  localparam int SWIDTH = 23;
  localparam int DEPTH  = 4;
  localparam int FWIDTH = 32;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              i_flush = 1'b0;
  logic [FWIDTH-1:0] i_a = '0;
  logic [FWIDTH-1:0] i_b = '0;
  logic              i_valid = 1'b0;
  logic              i_ready = 1'b0;
  logic              o_ready;
  logic [FWIDTH-1:0] o_a;
  logic [FWIDTH-1:0] o_b;
  logic              o_spec;
  logic              o_valid;
  logic [2:0]        o_count;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        spec;
  } pair_t;

  pair_t model_q[$];
  bit    model_live = 0;
  int    checks = 0;
  int    errors = 0;

  flp_mul_issue #(.EWIDTH(EWIDTH), .SWIDTH(SWIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .nrst    (nrst),
    .i_flush (i_flush),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_a     (o_a),
    .o_b     (o_b),
    .o_spec  (o_spec),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_count (o_count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Zero (not subnormal), infinity or NaN.
  function automatic logic spec_of(input logic [31:0] x);
    return (x[30:23] == 8'hFF) || ((x[30:23] == 8'h00) && (x[22:0] == 23'd0));
  endfunction

  function automatic logic [31:0] pa(input int k);
    return 32'h3F800000 + 32'(k * 16);
  endfunction

  function automatic logic [31:0] pb(input int k);
    return 32'h40400000 + 32'(k);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                                input logic rdy, input logic fl);
    i_valid = v;
    i_a     = a;
    i_b     = b;
    i_ready = rdy;
    i_flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the held pairs as a plain queue, updated at each rising edge.
  always @(posedge clk) begin
    bit do_pop;
    bit do_push;
    if (!nrst) begin
      model_q.delete();
      model_live = 1;
    end else if (i_flush) begin
      model_q.delete();
    end else begin
      do_pop  = (model_q.size() > 0) && i_ready;
      do_push = i_valid && (model_q.size() < DEPTH);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back('{a: i_a, b: i_b, spec: spec_of(i_a) | spec_of(i_b)});
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (model_live) begin
      check_output("model_count", 32'(o_count), 32'(model_q.size()));
      check_output("model_ready", 32'(o_ready), 32'(model_q.size() < DEPTH));
      check_output("model_valid", 32'(o_valid), 32'(model_q.size() > 0));
      if (model_q.size() > 0) begin
        check_output("model_a", o_a, model_q[0].a);
        check_output("model_b", o_b, model_q[0].b);
        check_output("model_spec", 32'(o_spec), 32'(model_q[0].spec));
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence.
  initial begin
    int in_idx;
    int out_idx;
    int cyc;
    logic [31:0] spec_b [4];

    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    nrst = 1'b0;
    step();
    step();
    check_output("reset_valid", 32'(o_valid), 32'd0);
    check_output("reset_count", 32'(o_count), 32'd0);
    check_output("reset_ready", 32'(o_ready), 32'd1);
    check_output("reset_spec", 32'(o_spec), 32'd0);
    check_output("reset_a", o_a, 32'h0);
    check_output("reset_b", o_b, 32'h0);

    // Single pair, latency one, popped on the next edge.
    nrst = 1'b1;
    apply_stimulus(1'b1, 32'h3F800000, 32'h40000000, 1'b1, 1'b0);
    step();
    check_output("single_valid", 32'(o_valid), 32'd1);
    check_output("single_a", o_a, 32'h3F800000);
    check_output("single_b", o_b, 32'h40000000);
    check_output("single_spec", 32'(o_spec), 32'd0);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    check_output("single_drained", 32'(o_valid), 32'd0);
    check_output("single_count", 32'(o_count), 32'd0);

    // Five pairs under backpressure: only four fit.
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1'b1, pa(k), pb(k), 1'b0, 1'b0);
      step();
      if (k == 3) begin
        check_output("fill_count4", 32'(o_count), 32'd4);
        check_output("fill_ready0", 32'(o_ready), 32'd0);
      end
    end
    check_output("fill_hold_count", 32'(o_count), 32'd4);
    check_output("fill_head", o_a, pa(0));
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int k = 1; k < 4; k++) begin
      step();
      check_output("drain_a", o_a, pa(k));
      check_output("drain_count", 32'(o_count), 32'(4 - k));
    end
    step();
    check_output("drain_empty", 32'(o_valid), 32'd0);
    check_output("drain_count0", 32'(o_count), 32'd0);

    // Full block, push and pop requested together: pop only.
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b1, pa(10 + k), pb(10 + k), 1'b0, 1'b0);
      step();
    end
    apply_stimulus(1'b1, pa(20), pb(20), 1'b1, 1'b0);
    step();
    check_output("full_pop_count", 32'(o_count), 32'd3);
    check_output("full_pop_ready", 32'(o_ready), 32'd1);
    check_output("full_pop_head", o_a, pa(11));
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (4) step();
    check_output("full_pop_empty", 32'(o_valid), 32'd0);

    // Special-operand flag.
    spec_b[0] = 32'h00000000;
    spec_b[1] = 32'h7F800000;
    spec_b[2] = 32'h7FC00000;
    spec_b[3] = 32'h00000001;
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b1, 32'h3F800000, spec_b[k], 1'b0, 1'b0);
      step();
    end
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check_output("spec_zero", 32'(o_spec), 32'd1);
    step();
    check_output("spec_inf", 32'(o_spec), 32'd1);
    step();
    check_output("spec_nan", 32'(o_spec), 32'd1);
    step();
    check_output("spec_subnormal", 32'(o_spec), 32'd0);
    step();

    // Flush with three pairs held and a push attempted in the same cycle.
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b1, pa(30 + k), pb(30 + k), 1'b0, 1'b0);
      step();
    end
    check_output("preflush_count", 32'(o_count), 32'd3);
    apply_stimulus(1'b1, pa(33), pb(33), 1'b0, 1'b1);
    step();
    check_output("flush_valid", 32'(o_valid), 32'd0);
    check_output("flush_count", 32'(o_count), 32'd0);
    check_output("flush_ready", 32'(o_ready), 32'd1);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (3) step();
    check_output("flush_no_emit", 32'(o_valid), 32'd0);

    // Reset in the middle of operation discards held pairs.
    for (int k = 0; k < 2; k++) begin
      apply_stimulus(1'b1, pa(40 + k), pb(40 + k), 1'b0, 1'b0);
      step();
    end
    nrst = 1'b0;
    apply_stimulus(1'b1, pa(42), pb(42), 1'b1, 1'b0);
    step();
    check_output("midreset_count", 32'(o_count), 32'd0);
    check_output("midreset_valid", 32'(o_valid), 32'd0);
    nrst = 1'b1;
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    check_output("midreset_after", 32'(o_valid), 32'd0);

    // Stream of 64 pairs with i_ready toggling 1010.
    in_idx  = 0;
    out_idx = 0;
    cyc     = 0;
    while (out_idx < 64 && cyc < 2000) begin
      apply_stimulus(in_idx < 64, pa(in_idx + 100), pb(in_idx + 100), (cyc % 2) == 0, 1'b0);
      if (o_valid && i_ready) begin
        check_output("stream_order", o_a, pa(out_idx + 100));
        out_idx++;
      end
      if (i_valid && (model_q.size() < DEPTH)) in_idx++;
      step();
      cyc++;
    end
    check_output("stream_out_total", 32'(out_idx), 32'd64);
    check_output("stream_in_total", 32'(in_idx), 32'd64);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    check_output("stream_final_empty", 32'(o_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
